// File: rtl/clock_ratio_detector.sv
// Measures the period and high time of a divided clock in clk cycles.
// One-shot or continuous measurement with saturation and a sticky overflow.
module clock_ratio_detector #(
  parameter int W           = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sig_in,
  input  logic         start,
  input  logic         cont,
  output logic [W-1:0] ratio,
  output logic [W-1:0] high_cnt,
  output logic         valid,
  output logic         overflow,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE
  } state_t;

  localparam logic [W-1:0] MAX = '1;
  localparam logic [W-1:0] ONE = W'(1);

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_sync;
  logic                   s_prev;
  logic                   rise;
  logic [W-1:0]           cnt;
  logic [W-1:0]           hcnt;
  logic [W-1:0]           hcnt_nxt;

  assign s_sync = sync_q[SYNC_STAGES-1];
  assign rise   = s_sync & ~s_prev;

  // High-time accumulator never wraps.
  assign hcnt_nxt = (s_sync && hcnt != MAX) ? hcnt + ONE : hcnt;

  // Bring sig_in into the clk domain and keep one cycle of history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      s_prev <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      s_prev <= s_sync;
    end
  end

  // Measurement FSM with registered results and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      hcnt     <= '0;
      ratio    <= '0;
      high_cnt <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
      busy     <= 1'b0;
    end else begin
      valid <= 1'b0;
      unique case (state)
        IDLE: begin
          // A start coinciding with a result pulse is not accepted.
          if (start && !valid) begin
            state    <= ARM;
            busy     <= 1'b1;
            cnt      <= '0;
            hcnt     <= '0;
            overflow <= 1'b0;
          end
        end
        ARM: begin
          if (rise) begin
            state <= MEASURE;
            cnt   <= ONE;
            hcnt  <= ONE;
          end else if (cnt == MAX) begin
            state    <= IDLE;
            busy     <= 1'b0;
            overflow <= 1'b1;
            valid    <= 1'b1;
            ratio    <= MAX;
            high_cnt <= '0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        MEASURE: begin
          if (rise) begin
            ratio    <= cnt;
            high_cnt <= hcnt;
            valid    <= 1'b1;
            if (cont) begin
              cnt  <= ONE;
              hcnt <= ONE;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (cnt == MAX) begin
            state    <= IDLE;
            busy     <= 1'b0;
            overflow <= 1'b1;
            valid    <= 1'b1;
            ratio    <= MAX;
            high_cnt <= hcnt;
          end else begin
            cnt  <= cnt + ONE;
            hcnt <= hcnt_nxt;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_ratio_detector.sv
// Scoreboard bench for clock_ratio_detector (W=8).
// Directed periodic sources; a monitor checks every valid pulse.
module tb_clock_ratio_detector;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sig_in = 1'b0;
  logic         start = 1'b0;
  logic         cont = 1'b0;
  logic [W-1:0] ratio;
  logic [W-1:0] high_cnt;
  logic         valid;
  logic         overflow;
  logic         busy;

  typedef struct {
    int r;
    int h;
    int o;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   last_v  = -1;
  int   gap_exp = 0;
  logic prev_v  = 1'b0;

  bit   gen_on = 1'b0;
  int   hi = 2;
  int   lo = 2;
  int   ph = 0;

  clock_ratio_detector #(.W(W), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .sig_in   (sig_in),
    .start    (start),
    .cont     (cont),
    .ratio    (ratio),
    .high_cnt (high_cnt),
    .valid    (valid),
    .overflow (overflow),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Periodic source: hi cycles high, lo cycles low.
  always @(negedge clk) begin
    if (gen_on) begin
      sig_in = (ph < hi);
      ph = (ph + 1 >= hi + lo) ? 0 : ph + 1;
    end else begin
      sig_in = 1'b0;
      ph = 0;
    end
  end

  // Monitor: pop and compare on each valid pulse.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst && valid) begin
      chk("valid_back_to_back", int'(prev_v), 0);
      if (gap_exp != 0 && last_v >= 0)
        chk("cont_gap", cyc - last_v, gap_exp);
      last_v = cyc;
      if (q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        e = q.pop_front();
        chk("ratio", int'(ratio), e.r);
        chk("high_cnt", int'(high_cnt), e.h);
        chk("overflow", int'(overflow), e.o);
      end
    end
    prev_v = valid;
  end

  task automatic push(input int r, input int h, input int o);
    exp_t e;
    e.r = r;
    e.h = h;
    e.o = o;
    q.push_back(e);
  endtask

  task automatic set_gen(input bit on, input int h, input int l);
    gen_on = 1'b0;
    @(negedge clk);
    hi = h;
    lo = l;
    gen_on = on;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (q.size() == 0 && !busy) break;
    end
    if (i >= budget) begin
      chk({name, "_timeout"}, 1, 0);
      q.delete();
    end
    repeat (3) @(negedge clk);
    #1;
    chk({name, "_busy_after"}, int'(busy), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ratio", int'(ratio), 0);
    chk("rst_high", int'(high_cnt), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_busy", int'(busy), 0);

    // Divide-by-4, single shot.
    set_gen(1'b1, 2, 2);
    push(4, 2, 0);
    pulse_start();
    #1;
    chk("busy_on_start", int'(busy), 1);
    wait_done("div4", 100);

    // Divide-by-10, continuous: six results, last closes the run.
    set_gen(1'b1, 5, 5);
    cont = 1'b1;
    for (int k = 0; k < 5; k++) push(10, 5, 0);
    last_v = -1;
    gap_exp = 10;
    pulse_start();
    for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
    push(10, 5, 0);
    cont = 1'b0;
    wait_done("div10_cont", 200);
    gap_exp = 0;

    // High 3, low 5.
    set_gen(1'b1, 3, 5);
    push(8, 3, 0);
    pulse_start();
    wait_done("h3l5", 100);

    // Input stuck low: ARM timeout.
    set_gen(1'b0, 1, 1);
    push(255, 0, 1);
    pulse_start();
    wait_done("timeout", 400);
    chk("ovf_sticky", int'(overflow), 1);

    // Restart attempt during MEASURE is ignored; start clears overflow.
    set_gen(1'b1, 3, 5);
    push(8, 3, 0);
    pulse_start();
    repeat (12) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("restart_ignored", 100);
    chk("ovf_cleared", int'(overflow), 0);

    // Reset mid-measurement discards the result.
    set_gen(1'b1, 5, 5);
    pulse_start();
    repeat (15) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_ratio", int'(ratio), 0);
    chk("mid_rst_high", int'(high_cnt), 0);
    chk("mid_rst_valid", int'(valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_ovf", int'(overflow), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    chk("post_rst_idle", int'(busy), 0);

    // Divide-by-6 after reset.
    set_gen(1'b1, 3, 3);
    push(6, 3, 0);
    pulse_start();
    wait_done("div6", 100);

    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
